muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the MIPS HI/LO operations MULT, MULTU, DIV and DIVU, placed beside the single-cycle execute ALU.
- Accepts a start pulse from decode/execute and runs 32 radix-2 iterations: shift-add for multiply, restoring division for divide.
- Owns the HI and LO registers, serves MTHI/MTLO writes, and drives busy so the hazard logic can stall MFHI, MFLO and further HI/LO instructions.

---
 rtl/muldiv_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: 32-iteration shift-add multiply and restoring
// divide, with MTHI/MTLO writes and a busy flag for the hazard unit.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d, div0_q, div0_d;

    logic [WIDTH:0]     rem_shift_s, diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;

    // Divide keeps {remainder, dividend/quotient} in acc_q; these are the
    // trial subtract and the sign fix-ups applied on the way out of FIX.
    always_comb begin
        rem_shift_s = acc_q[2*WIDTH-1:WIDTH-1];
        diff_s      = rem_shift_s - {1'b0, b_q};
        prod_s      = (op_q[0] && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
        rem_s       = (op_q[0] && sign_a_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (b_q == {WIDTH{1'b0}}) begin
            quot_s = {WIDTH{1'b1}};
        end else if (op_q[0] && (sign_a_q ^ sign_b_q)) begin
            quot_s = -acc_q[WIDTH-1:0];
        end else begin
            quot_s = acc_q[WIDTH-1:0];
        end
    end

    // Sequencer next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        div0_d   = div0_q;
        case (state_q)
            S_IDLE: begin
                if (hi_we) begin
                    hi_d = wdata;
                end else begin
                    hi_d = hi_q;
                end
                if (lo_we) begin
                    lo_d = wdata;
                end else begin
                    lo_d = lo_q;
                end
                // Operands are converted to magnitudes as they are captured.
                if (start && !abort) begin
                    state_d  = S_PREP;
                    op_d     = op;
                    sign_a_d = op[0] & rs_data[WIDTH-1];
                    sign_b_d = op[0] & rt_data[WIDTH-1];
                    a_d      = (op[0] && rs_data[WIDTH-1]) ? -rs_data : rs_data;
                    b_d      = (op[0] && rt_data[WIDTH-1]) ? -rt_data : rt_data;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                    acc_d   = op_q[1] ? {{WIDTH{1'b0}}, a_q} : {(2*WIDTH){1'b0}};
                    mcand_d = {{WIDTH{1'b0}}, a_q};
                    cnt_d   = {CW{1'b0}};
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[1]) begin
                        acc_d = {(diff_s[WIDTH] ? rem_shift_s[WIDTH-1:0] : diff_s[WIDTH-1:0]),
                                 acc_q[WIDTH-2:0], ~diff_s[WIDTH]};
                    end else begin
                        acc_d = acc_q + (b_q[cnt_q] ? mcand_q : {(2*WIDTH){1'b0}});
                    end
                    mcand_d = mcand_q << 1;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (abort) begin
                    done_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        hi_d   = rem_s;
                        lo_d   = quot_s;
                        div0_d = (b_q == {WIDTH{1'b0}});
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO/div0 come from a
// 64-bit arithmetic reference model and are compared when done pulses.
module tb_muldiv_sequencer;
    logic        clock = 1'b0;
    logic        reset, start, abort, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, wdata;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
    } exp_t;

    exp_t        scb[$];
    logic        exp_div0;
    logic [31:0] model_hi, model_lo;

    always #5 clock = ~clock;

    muldiv_sequencer #(.WIDTH(32), .ITER(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .abort(abort),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        logic signed [63:0] sa, sbv, q, r;
        sa   = {{32{a[31]}}, a};
        sbv  = {{32{b[31]}}, b};
        e.d0 = exp_div0;
        case (o)
            2'b00: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a; e.d0 = 1'b1;
                end else if (o == 2'b10) begin
                    e.lo = a / b; e.hi = a % b; e.d0 = 1'b0;
                end else begin
                    q = sa / sbv; r = sa % sbv;
                    e.lo = q[31:0]; e.hi = r[31:0]; e.d0 = 1'b0;
                end
            end
        endcase
        return e;
    endfunction

    // mode: 0 plain, 1 extra start while busy, 2 hi_we while busy, 3 hi_we with start
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int mode, input string name);
        exp_t e, g;
        int   k;
        bit   got, busy_ok;
        e = model(o, a, b);
        exp_div0 = e.d0;
        scb.push_back(e);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        if (mode == 3) begin hi_we = 1'b1; wdata = 32'h5A5A_0F0F; end
        @(negedge clock);
        start = 1'b0; hi_we = 1'b0; rs_data = ~a; rt_data = ~b; op = ~o;
        if (mode == 3) begin
            checks++;
            if (hi !== 32'h5A5A_0F0F) begin failures++; $display("FAIL %s hi_with_start: got %h expected %h", name, hi, 32'h5A5A_0F0F); end
        end
        got = 1'b0; busy_ok = 1'b1; k = 1;
        while (!got && k <= 40) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (k <= 34 && busy !== 1'b1) busy_ok = 1'b0;
                if (mode == 1 && k == 5) begin start = 1'b1; op = 2'b10; rs_data = 32'd100; rt_data = 32'd7; end
                if (mode == 1 && k == 6) start = 1'b0;
                if (mode == 2 && k == 3) begin hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
                if (mode == 2 && k == 4) begin
                    hi_we = 1'b0;
                    checks++;
                    if (hi !== model_hi) begin failures++; $display("FAIL %s hi_we_busy: got %h expected %h", name, hi, model_hi); end
                end
                @(negedge clock);
                k++;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s timeout: no done within 40 cycles", name);
            void'(scb.pop_front());
        end else begin
            g = scb.pop_front();
            model_hi = g.hi; model_lo = g.lo;
            if (k != 35) begin failures++; $display("FAIL %s latency: got %0d expected 35", name, k); end
            checks++;
            if (!busy_ok || busy !== 1'b0) begin failures++; $display("FAIL %s busy_profile: busy_ok=%0b busy_at_done=%b expected 1/0", name, busy_ok, busy); end
            checks++;
            if (hi !== g.hi) begin failures++; $display("FAIL %s hi: got %h expected %h", name, hi, g.hi); end
            checks++;
            if (lo !== g.lo) begin failures++; $display("FAIL %s lo: got %h expected %h", name, lo, g.lo); end
            checks++;
            if (div0 !== g.d0) begin failures++; $display("FAIL %s div0: got %b expected %b", name, div0, g.d0); end
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL %s done_width: got %b expected 0", name, done); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; rs_data = 32'd0; rt_data = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_div0 = 1'b0; model_hi = 32'd0; model_lo = 32'd0;
        checks++;
        if ({busy, done, div0, hi, lo} !== 67'd0) begin
            failures++; $display("FAIL reset_state: got busy=%b done=%b div0=%b hi=%h lo=%h expected all 0", busy, done, div0, hi, lo);
        end
    endtask

    task automatic test_mult();
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
        do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, "mult_neg");
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1, "mult_min_dup_start");
    endtask

    task automatic test_div();
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
        do_op(2'b10, 32'd100, 32'd7, 2, "divu_100_7");
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 3, "div_overflow");
    endtask

    task automatic test_div0();
        do_op(2'b10, 32'h0000_1234, 32'd0, 0, "divu_zero");
        do_op(2'b00, 32'd3, 32'd5, 0, "multu_keeps_div0");
        do_op(2'b10, 32'd9, 32'd3, 0, "divu_clears_div0");
    endtask

    task automatic test_mtlo();
        lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clock);
        lo_we = 1'b0;
        model_lo = 32'hA5A5_A5A5;
        checks++;
        if (lo !== model_lo || hi !== model_hi) begin
            failures++; $display("FAIL mtlo: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, model_hi, model_lo);
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        // abort together with start in IDLE suppresses the start
        start = 1'b1; abort = 1'b1; op = 2'b00; rs_data = 32'd6; rt_data = 32'd7;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_with_start: got busy=%b expected 0", busy); end
        saw_done = 1'b0;
        op = 2'b01; rs_data = 32'hFFFF_FFFD; rt_data = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k < 12; k++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clock);
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || saw_done || hi !== model_hi || lo !== model_lo) begin
            failures++;
            $display("FAIL abort_run: got busy=%b done=%b early_done=%0b hi=%h lo=%h expected 0/0/0 hi=%h lo=%h",
                     busy, done, saw_done, hi, lo, model_hi, model_lo);
        end
        do_op(2'b01, 32'h0000_0010, 32'hFFFF_FFF0, 0, "start_after_abort");
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            do_op(o, a, b, 0, "random");
        end
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        do_op(2'b11, 32'hFFFF_FF00, 32'd0, 0, "div_zero_before_reset");
        saw_done = 1'b0;
        op = 2'b00; rs_data = 32'd1234; rt_data = 32'd5678; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k < 12; k++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_div0 = 1'b0; model_hi = 32'd0; model_lo = 32'd0;
        checks++;
        if ({busy, done, div0, hi, lo} !== 67'd0) begin
            failures++; $display("FAIL reset_mid_run: got busy=%b done=%b div0=%b hi=%h lo=%h expected all 0", busy, done, div0, hi, lo);
        end
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (saw_done) begin failures++; $display("FAIL reset_no_done: got done pulse expected none"); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_mtlo();
        test_abort();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
